// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared encodings for the IF/ID pipeline register
package if_id_stage_pkg;

  localparam logic [6:0]  OPC_LOAD     = 7'b000_0011;
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_SHADOW = 2'd2
  } ifid_state_e;

  function automatic logic is_load(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB] == OPC_LOAD;
  endfunction

endpackage

// File: rtl/if_id_stage_sat_cnt.sv
// rtl/if_id_stage_sat_cnt.sv - saturating event counter with synchronous clear
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID register with hold, flush shadow, bubble and stats
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = RV_NOP_INSTR,
  parameter int          FLUSH_SHADOW = 1,
  parameter int          CNT_W        = 16,
  parameter int          MAX_HOLD     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic             valid_in,
  input  logic             hold_in,
  input  logic             flush_in,
  output logic [31:0]      pc_out,
  output logic [31:0]      instr_out,
  output logic             valid_out,
  output logic [6:0]       opcode_out,
  output logic [4:0]       rs1_addr_out,
  output logic [4:0]       rs2_addr_out,
  output logic             bubble_out,
  output logic [CNT_W-1:0] stall_cnt_out,
  output logic [CNT_W-1:0] flush_cnt_out,
  output logic             hold_err_out
);

  localparam logic [1:0] SHADOW_INIT = 2'(FLUSH_SHADOW);
  localparam int         HW          = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  ifid_state_e state_q, state_d;
  logic [1:0]  shadow_q, shadow_d;
  logic [31:0] pc_q, instr_q;
  logic        valid_q;
  logic        load, kill, stall_inc;
  logic [HW-1:0] hold_run_q;
  logic        hold_err_q;
  logic        hold_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      shadow_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  // Flush outranks hold; RUN and STALL differ only in whether the word is taken.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    load      = 1'b0;
    kill      = 1'b0;
    stall_inc = 1'b0;
    if (flush_in) begin
      kill     = 1'b1;
      shadow_d = SHADOW_INIT;
      state_d  = ST_SHADOW;
    end else begin
      stall_inc = hold_in;
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (hold_in) begin
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
            load    = 1'b1;
          end
        end
        ST_SHADOW: begin
          shadow_d = shadow_q - 2'd1;
          if (shadow_q <= 2'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (kill) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (load) begin
      pc_q    <= pc_in;
      instr_q <= instr_in;
      valid_q <= valid_in;
    end
  end

  // Watchdog tracks consecutive hold requests that were not overridden by a flush.
  assign hold_hit = hold_in && !flush_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_run_q <= '0;
      hold_err_q <= 1'b0;
    end else begin
      if (!hold_hit) begin
        hold_run_q <= '0;
      end else if (hold_run_q != HOLD_LIMIT) begin
        hold_run_q <= hold_run_q + HOLD_ONE;
      end
      if (hold_hit && (hold_run_q == HOLD_LIMIT - HOLD_ONE)) hold_err_q <= 1'b1;
    end
  end

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (1'b0),
    .cnt (stall_cnt_out)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (kill),
    .clr (1'b0),
    .cnt (flush_cnt_out)
  );

  assign pc_out       = pc_q;
  assign valid_out    = valid_q;
  assign instr_out    = valid_q ? instr_q : NOP_INSTR;
  assign opcode_out   = instr_out[OPC_MSB:OPC_LSB];
  assign rs1_addr_out = instr_out[RS1_MSB:RS1_LSB];
  assign rs2_addr_out = instr_out[RS2_MSB:RS2_LSB];
  assign bubble_out   = !valid_q || hold_in;
  assign hold_err_out = hold_err_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - randomized and directed checks of if_id_stage
module tb_if_id_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          SHADOW_N = 1;
  localparam int          MAXH     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_in = '0, instr_in = '0;
  logic        valid_in = 1'b0, hold_in = 1'b0, flush_in = 1'b0;

  logic [31:0] pc_out, instr_out, pc_out_b, instr_out_b;
  logic        valid_out, bubble_out, hold_err_out, valid_out_b, bubble_out_b, hold_err_out_b;
  logic [6:0]  opcode_out, opcode_out_b;
  logic [4:0]  rs1_addr_out, rs2_addr_out, rs1_addr_out_b, rs2_addr_out_b;
  logic [15:0] stall_cnt_out, flush_cnt_out;
  logic [3:0]  stall_cnt_out_b, flush_cnt_out_b;

  if_id_stage dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .valid_in(valid_in),
    .hold_in(hold_in), .flush_in(flush_in), .pc_out(pc_out), .instr_out(instr_out),
    .valid_out(valid_out), .opcode_out(opcode_out), .rs1_addr_out(rs1_addr_out),
    .rs2_addr_out(rs2_addr_out), .bubble_out(bubble_out), .stall_cnt_out(stall_cnt_out),
    .flush_cnt_out(flush_cnt_out), .hold_err_out(hold_err_out)
  );

  if_id_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .valid_in(valid_in),
    .hold_in(hold_in), .flush_in(flush_in), .pc_out(pc_out_b), .instr_out(instr_out_b),
    .valid_out(valid_out_b), .opcode_out(opcode_out_b), .rs1_addr_out(rs1_addr_out_b),
    .rs2_addr_out(rs2_addr_out_b), .bubble_out(bubble_out_b), .stall_cnt_out(stall_cnt_out_b),
    .flush_cnt_out(flush_cnt_out_b), .hold_err_out(hold_err_out_b)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: live word, words left to discard, plain integer statistics.
  logic [31:0] m_pc, m_instr;
  logic        m_valid, m_err;
  int          m_shadow, m_stall, m_flush, m_stall4, m_flush4, m_run;

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_err = 1'b0;
    m_shadow = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0; m_run = 0;
  endtask

  task automatic model_step();
    if (flush_in) begin
      m_valid  = 1'b0;
      m_shadow = SHADOW_N;
      m_flush  = sat_inc(m_flush, 65535);
      m_flush4 = sat_inc(m_flush4, 15);
      m_run    = 0;
    end else begin
      if (hold_in) begin
        m_stall  = sat_inc(m_stall, 65535);
        m_stall4 = sat_inc(m_stall4, 15);
        m_run    = m_run + 1;
        if (m_run >= MAXH) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
      if (m_shadow > 0) begin
        m_shadow = m_shadow - 1;
      end else if (!hold_in) begin
        m_pc = pc_in; m_instr = instr_in; m_valid = valid_in;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic v, input logic h, input logic f);
    pc_in = pc; instr_in = $urandom; valid_in = v; hold_in = h; flush_in = f;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    n_total++;
    if ({pc_out, instr_out, valid_out, bubble_out, hold_err_out} !== {32'h0, NOP, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_outs: pc=%h instr=%h v=%b b=%b err=%b, want 0/%h/0/1/0", pc_out, instr_out, valid_out, bubble_out, hold_err_out, NOP);
    else n_pass++;
    n_total++;
    if ({stall_cnt_out, flush_cnt_out, stall_cnt_out_b, flush_cnt_out_b} !== 40'h0)
      $display("FAIL reset_cnts: stall=%0d flush=%0d stall4=%0d flush4=%0d, want 0", stall_cnt_out, flush_cnt_out, stall_cnt_out_b, flush_cnt_out_b);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_load();
    drive(32'h100, 1'b1, 1'b0, 1'b0);
    instr_in = 32'h00A3_2083;
    tick();
    n_total++;
    if ({pc_out, valid_out, bubble_out, instr_out} !== {32'h100, 1'b1, 1'b0, 32'h00A3_2083})
      $display("FAIL load: pc=%h v=%b b=%b instr=%h, want 100/1/0/00a32083", pc_out, valid_out, bubble_out, instr_out);
    else n_pass++;
    n_total++;
    if ({opcode_out, rs1_addr_out, rs2_addr_out} !== {7'h03, 5'd6, 5'd10})
      $display("FAIL load_fields: op=%h rs1=%0d rs2=%0d, want 03/6/10", opcode_out, rs1_addr_out, rs2_addr_out);
    else n_pass++;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(32'h104 + 32'(4 * i), 1'b1, 1'b1, 1'b0);
      tick();
      n_total++;
      if ({pc_out, valid_out, bubble_out} !== {32'h100, 1'b1, 1'b1} || stall_cnt_out !== 16'(i + 1))
        $display("FAIL hold_%0d: pc=%h v=%b b=%b stall=%0d, want 100/1/1/%0d", i, pc_out, valid_out, bubble_out, stall_cnt_out, i + 1);
      else n_pass++;
    end
    drive(32'h110, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (pc_out !== 32'h110 || stall_cnt_out !== 16'd3 || hold_err_out !== 1'b0)
      $display("FAIL hold_release: pc=%h stall=%0d err=%b, want 110/3/0", pc_out, stall_cnt_out, hold_err_out);
    else n_pass++;
  endtask

  task automatic test_flush();
    drive(32'h1F0, 1'b1, 1'b0, 1'b1);
    tick();
    n_total++;
    if ({valid_out, instr_out, bubble_out} !== {1'b0, NOP, 1'b1} || flush_cnt_out !== 16'd1)
      $display("FAIL flush_edge: v=%b instr=%h b=%b fcnt=%0d, want 0/%h/1/1", valid_out, instr_out, bubble_out, flush_cnt_out, NOP);
    else n_pass++;
    drive(32'h200, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (valid_out !== 1'b0 || instr_out !== NOP)
      $display("FAIL flush_shadow_drop: v=%b pc=%h, want v=0", valid_out, pc_out);
    else n_pass++;
    drive(32'h300, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (pc_out !== 32'h300 || valid_out !== 1'b1 || flush_cnt_out !== 16'd1)
      $display("FAIL flush_resume: pc=%h v=%b fcnt=%0d, want 300/1/1", pc_out, valid_out, flush_cnt_out);
    else n_pass++;
  endtask

  task automatic test_flush_hold();
    drive(32'h310, 1'b1, 1'b1, 1'b1);
    tick();
    n_total++;
    if (stall_cnt_out !== 16'd3 || flush_cnt_out !== 16'd2 || valid_out !== 1'b0)
      $display("FAIL flush_hold: stall=%0d fcnt=%0d v=%b, want 3/2/0", stall_cnt_out, flush_cnt_out, valid_out);
    else n_pass++;
    drive(32'h314, 1'b1, 1'b1, 1'b0);
    tick();
    n_total++;
    if (stall_cnt_out !== 16'd4 || valid_out !== 1'b0 || bubble_out !== 1'b1)
      $display("FAIL shadow_hold: stall=%0d v=%b b=%b, want 4/0/1", stall_cnt_out, valid_out, bubble_out);
    else n_pass++;
    drive(32'h400, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (pc_out !== 32'h400 || valid_out !== 1'b1)
      $display("FAIL shadow_exit: pc=%h v=%b, want 400/1", pc_out, valid_out);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < MAXH; i++) begin
      drive(32'h500, 1'b1, 1'b1, 1'b0);
      tick();
      n_total++;
      if (hold_err_out !== (i == MAXH - 1))
        $display("FAIL watchdog_%0d: err=%b, want %b", i, hold_err_out, (i == MAXH - 1));
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(32'h504 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    n_total++;
    if (hold_err_out !== 1'b1 || pc_out !== 32'h50C)
      $display("FAIL watchdog_sticky: err=%b pc=%h, want 1/50c", hold_err_out, pc_out);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(32'h600, 1'b1, 1'b1, 1'b0);
      tick();
    end
    n_total++;
    if (stall_cnt_out_b !== 4'd15 || stall_cnt_out !== 16'(m_stall))
      $display("FAIL stall_saturate: stall4=%0d stall16=%0d, want 15/%0d", stall_cnt_out_b, stall_cnt_out, m_stall);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(32'h700, 1'b1, 1'b1, 1'b0);
    tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_total++;
    if ({pc_out, instr_out, valid_out, bubble_out, hold_err_out, stall_cnt_out, stall_cnt_out_b} !== {32'h0, NOP, 1'b0, 1'b1, 1'b0, 16'h0, 4'h0})
      $display("FAIL async_reset_hold: pc=%h instr=%h v=%b err=%b stall=%0d stall4=%0d", pc_out, instr_out, valid_out, hold_err_out, stall_cnt_out, stall_cnt_out_b);
    else n_pass++;
    tick();
    rst = 1'b1;
    drive(32'h800, 1'b1, 1'b0, 1'b1);
    tick();
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (valid_out !== 1'b0 || flush_cnt_out !== 16'd0)
      $display("FAIL async_reset_shadow: v=%b fcnt=%0d, want 0/0", valid_out, flush_cnt_out);
    else n_pass++;
    tick();
    rst = 1'b1;
    drive(32'h900, 1'b1, 1'b0, 1'b0);
    tick();
    n_total++;
    if (pc_out !== 32'h900 || valid_out !== 1'b1)
      $display("FAIL reset_exits_shadow: pc=%h v=%b, want 900/1", pc_out, valid_out);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_i;
    for (int c = 0; c < 400; c++) begin
      drive($urandom, ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      tick();
      exp_i = m_valid ? m_instr : NOP;
      n_total++;
      if ({pc_out, instr_out, valid_out, bubble_out} !== {m_pc, exp_i, m_valid, (!m_valid || hold_in)})
        $display("FAIL rand_data c%0d: pc=%h instr=%h v=%b b=%b, want %h/%h/%b/%b", c, pc_out, instr_out, valid_out, bubble_out, m_pc, exp_i, m_valid, (!m_valid || hold_in));
      else n_pass++;
      n_total++;
      if ({opcode_out, rs1_addr_out, rs2_addr_out} !== {exp_i[6:0], exp_i[19:15], exp_i[24:20]})
        $display("FAIL rand_fields c%0d: op=%h rs1=%0d rs2=%0d", c, opcode_out, rs1_addr_out, rs2_addr_out);
      else n_pass++;
      n_total++;
      if (stall_cnt_out !== 16'(m_stall) || flush_cnt_out !== 16'(m_flush) || hold_err_out !== m_err ||
          stall_cnt_out_b !== 4'(m_stall4) || flush_cnt_out_b !== 4'(m_flush4))
        $display("FAIL rand_stats c%0d: stall=%0d flush=%0d err=%b s4=%0d f4=%0d, want %0d/%0d/%b/%0d/%0d", c, stall_cnt_out, flush_cnt_out, hold_err_out, stall_cnt_out_b, flush_cnt_out_b, m_stall, m_flush, m_err, m_stall4, m_flush4);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_hold();
    test_flush();
    test_flush_hold();
    test_watchdog();
    test_saturation();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register of the RV32 core and the receiving end of the load-use hold issued by the bubble unit. Captures the fetched PC/instruction each cycle, freezes on hold, kills wrong-path words on a taken-branch flush, and turns its own content into a NOP bubble toward ID/EX when required. Also exports decoded register fields to the bubble unit, and maintains stall/flush statistics plus a stuck-hold watchdog.

## Interface
- `RESET_PC`, 32'h0000_0000, value of `pc_out` out of reset.
- `NOP_INSTR`, 32'h0000_0013, instruction emitted as a bubble (`addi x0,x0,0`).
- `FLUSH_SHADOW`, 1, number of fetch words discarded after a flush (1..3).
- `CNT_W`, 16, width of the statistics counters.
- `MAX_HOLD`, 8, consecutive hold cycles before `hold_err_out` asserts.
- `clk` in 1, rising-edge clock.
- `rst` in 1, asynchronous active-low reset.
- `pc_in` in 32, PC of the fetched word.
- `instr_in` in 32, fetched instruction.
- `valid_in` in 1, fetch word valid.
- `hold_in` in 1, hold request from the bubble unit.
- `flush_in` in 1, taken branch/jump resolved in EX.
- `pc_out` out 32, registered PC to ID.
- `instr_out` out 32, registered instruction, or `NOP_INSTR` when invalid.
- `valid_out` out 1, register holds a live instruction.
- `opcode_out` out 7, `instr_out[6:0]`, to the bubble unit.
- `rs1_addr_out` out 5, `instr_out[19:15]`.
- `rs2_addr_out` out 5, `instr_out[24:20]`.
- `bubble_out` out 1, ID/EX must load a NOP this cycle.
- `stall_cnt_out` out CNT_W, saturating count of hold cycles.
- `flush_cnt_out` out CNT_W, saturating count of flush events.
- `hold_err_out` out 1, sticky watchdog flag.

## Operation
- States: RUN, STALL, SHADOW.
- Priority every cycle: reset > flush > hold > load.
- RUN: on edge, capture `pc_in`/`instr_in`; `valid_out <= valid_in`.
- `hold_in` with no flush: go to STALL, keep contents, `stall_cnt` +1. Stay in STALL while hold is asserted. Return to RUN on the first cycle without hold, capturing that cycle's fetch word.
- `flush_in` in any state: `valid_out <= 0`, `instr_out <= NOP_INSTR`, shadow counter loads `FLUSH_SHADOW`, go to SHADOW, `flush_cnt` +1. Hold is ignored in the same cycle.
- SHADOW: incoming words are discarded (`valid_out` stays 0) and the shadow counter decrements. At zero, go to RUN and capture the next word. A flush in SHADOW reloads the counter and is counted.
- `instr_out` = stored instruction when `valid_out`=1, else `NOP_INSTR`. Field outputs derive from `instr_out`.
- `bubble_out = !valid_out | hold_in` (combinational).
- Counters saturate at all-ones and never wrap.
- Watchdog: counts consecutive hold cycles and clears on any non-hold cycle. Reaching `MAX_HOLD` sets `hold_err_out`, which stays set until reset.

## Timing
- Reset values: `pc_out`=RESET_PC, `instr_out`=NOP_INSTR, `valid_out`=0, `bubble_out`=1, counters 0, `hold_err_out`=0, state RUN.
- Fetch to `*_out` latency: 1 cycle.
- `hold_in`/`flush_in` are sampled on the same edge as the data. `bubble_out` responds combinationally to `hold_in`.
- Reset asserted mid-STALL or mid-SHADOW: outputs go to reset values immediately. The first edge after release is RUN.
- Hold in the cycle after a flush, while in SHADOW: ignored. Nothing live exists to freeze. The stall counter is still incremented.

## Structure
- Shared header/package holds `OPC_LOAD`, `NOP_INSTR` encoding, the state encoding, and the field bit ranges.
- One sub-module, `sat_cnt` (parameterised width; inc, clear, saturate), instantiated twice.

## Test plan
- Reset release, `valid_in`=1, `pc_in`=0x100 -> next edge `pc_out`=0x100, `valid_out`=1, `bubble_out`=0.
- `hold_in` high for 3 cycles with `pc_in` advancing 0x104..0x10C -> `pc_out` stays 0x100, `bubble_out`=1, `stall_cnt_out`=3. Then 0x110 is captured.
- `flush_in` with `FLUSH_SHADOW`=1, `pc_in`=0x200 then 0x300 -> 0x200 dropped, `valid_out`=0 for 2 edges, then `pc_out`=0x300, `flush_cnt_out`=1.
- `flush_in` and `hold_in` together -> flush wins, `stall_cnt_out` unchanged, state SHADOW.
- Hold held 8 cycles with `MAX_HOLD`=8 -> `hold_err_out`=1 and remains 1 after hold drops, until `rst` low.
- `CNT_W`=4, 20 hold cycles -> `stall_cnt_out`=15. Async reset mid-hold -> all outputs at reset values without a clock edge.
